// File: rtl/arbitro_serial_pkg.sv
// Shared types and constants for the serial transmitter arbiter.
// States double as their debug codes.
package arbitro_serial_pkg;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned W_DADO = 8;
  localparam int unsigned W_TAM  = 2;

  typedef enum logic [3:0] {
    IDLE = 4'b0000,
    LOAD = 4'b0001,
    SEND = 4'b0010,
    WAIT = 4'b0011,
    DONE = 4'b0100
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'b1111;

  typedef logic [1:0] idx_req_t;

  function automatic idx_req_t onehot_para_idx(input logic [N_REQ-1:0] oh);
    idx_req_t r;
    case (oh)
      3'b010:  r = 2'd1;
      3'b100:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [W_TAM-1:0] fatia_tam(input logic [N_REQ*W_TAM-1:0] tam,
                                                 input idx_req_t i);
    logic [W_TAM-1:0] r;
    case (i)
      2'd1:    r = tam[3:2];
      2'd2:    r = tam[5:4];
      default: r = tam[1:0];
    endcase
    return r;
  endfunction

  function automatic logic [W_DADO-1:0] fatia_dados(input logic [N_REQ*W_DADO-1:0] dados,
                                                    input idx_req_t i);
    logic [W_DADO-1:0] r;
    case (i)
      2'd1:    r = dados[15:8];
      2'd2:    r = dados[23:16];
      default: r = dados[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arbitro_serial_if.sv
// Requester / transmitter side bundle of the serial arbiter.
interface arbitro_serial_if;
  import arbitro_serial_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*W_TAM-1:0]  tam;
  logic [N_REQ*W_DADO-1:0] dados;
  logic                    pronto_serial;
  logic [N_REQ-1:0]        grant;
  logic [W_TAM-1:0]        byte_idx;
  logic [W_DADO-1:0]       tx_dados;
  logic                    partida_tx;
  logic [N_REQ-1:0]        ack;
  logic                    ocupado;
  logic [3:0]              db_estado;

  modport slave (
    input  req, tam, dados, pronto_serial,
    output grant, byte_idx, tx_dados, partida_tx, ack, ocupado, db_estado
  );

  modport master (
    output req, tam, dados, pronto_serial,
    input  grant, byte_idx, tx_dados, partida_tx, ack, ocupado, db_estado
  );

endinterface

// File: rtl/arbitro_serial_rr_prioridade.sv
// Round-robin picker: priority is ponteiro+1, ponteiro+2, ponteiro (mod 3).
module rr_prioridade
  import arbitro_serial_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_req_t         ponteiro,
  output logic [N_REQ-1:0] vencedor,
  output logic             valido
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] rot_venc;

  // Rotate so bit 0 is always the highest-priority requester, pick, rotate back.
  always_comb begin
    case (ponteiro)
      2'd0:    rot = {req[0], req[2], req[1]};
      2'd1:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase

    rot_venc = '0;
    if (rot[0])      rot_venc = 3'b001;
    else if (rot[1]) rot_venc = 3'b010;
    else if (rot[2]) rot_venc = 3'b100;

    case (ponteiro)
      2'd0:    vencedor = {rot_venc[1], rot_venc[0], rot_venc[2]};
      2'd1:    vencedor = {rot_venc[0], rot_venc[2], rot_venc[1]};
      default: vencedor = rot_venc;
    endcase

    valido = |req;
  end

endmodule

// File: rtl/arbitro_serial.sv
// Round-robin arbiter and byte sequencer in front of the shared serial transmitter.
module arbitro_serial
  import arbitro_serial_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  arbitro_serial_if.slave  bus
);

  estado_t           estado, prox;
  logic [N_REQ-1:0]  venc_oh, grant_r, pick_oh, ack_c;
  idx_req_t          venc_idx, ponteiro;
  logic [W_TAM-1:0]  tam_r, byte_idx_r;
  logic [W_DADO-1:0] tx_r;
  logic              pick_valido;
  logic              pega, carrega_tx, avanca, fim, abandona;
  logic              partida_c, ocupado_c;
  logic [3:0]        db_c;

  rr_prioridade u_rr (
    .req      (bus.req),
    .ponteiro (ponteiro),
    .vencedor (pick_oh),
    .valido   (pick_valido)
  );

  always_ff @(posedge clock) begin
    if (reset) estado <= IDLE;
    else       estado <= prox;
  end

  always_comb begin
    prox       = estado;
    pega       = 1'b0;
    carrega_tx = 1'b0;
    avanca     = 1'b0;
    fim        = 1'b0;
    abandona   = 1'b0;
    partida_c  = 1'b0;
    ack_c      = '0;
    ocupado_c  = 1'b1;
    db_c       = estado;
    case (estado)
      IDLE: begin
        ocupado_c = 1'b0;
        if (pick_valido) begin
          pega = 1'b1;
          prox = LOAD;
        end
      end
      LOAD: begin
        carrega_tx = 1'b1;
        prox       = SEND;
      end
      SEND: begin
        partida_c = 1'b1;
        prox      = WAIT;
      end
      WAIT: begin
        if (bus.pronto_serial) begin
          if (byte_idx_r != tam_r) begin
            avanca = 1'b1;
            prox   = LOAD;
          end else begin
            prox = DONE;
          end
        end
      end
      DONE: begin
        ack_c = venc_oh;
        fim   = 1'b1;
        prox  = IDLE;
      end
      default: begin
        db_c     = DB_INVALIDO;
        abandona = 1'b1;
        prox     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      venc_oh    <= '0;
      venc_idx   <= '0;
      tam_r      <= '0;
      byte_idx_r <= '0;
      tx_r       <= '0;
      grant_r    <= '0;
      ponteiro   <= 2'd2;
    end else begin
      if (pega) begin
        venc_oh    <= pick_oh;
        venc_idx   <= onehot_para_idx(pick_oh);
        tam_r      <= fatia_tam(bus.tam, onehot_para_idx(pick_oh));
        byte_idx_r <= '0;
        grant_r    <= pick_oh;
      end
      if (carrega_tx) tx_r <= fatia_dados(bus.dados, venc_idx);
      if (avanca)     byte_idx_r <= byte_idx_r + 2'd1;
      if (fim)        ponteiro <= venc_idx;
      if (fim || abandona) grant_r <= '0;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.byte_idx   = byte_idx_r;
  assign bus.tx_dados   = tx_r;
  assign bus.partida_tx = partida_c;
  assign bus.ack        = ack_c;
  assign bus.ocupado    = ocupado_c;
  assign bus.db_estado  = db_c;

endmodule

// File: tb/tb_arbitro_serial.sv
// Directed bench for arbitro_serial: requester model answers dados from byte_idx.
module tb_arbitro_serial;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n_partida = 0;
  int n0;
  logic [7:0] msg [3][4];

  arbitro_serial_if bus();

  arbitro_serial dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign bus.dados = {msg[2][bus.byte_idx], msg[1][bus.byte_idx], msg[0][bus.byte_idx]};

  always @(posedge clock) if (bus.partida_tx === 1'b1) n_partida <= n_partida + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Starts at the negedge inside LOAD; ends at the negedge of the next LOAD or DONE.
  task automatic envia_byte(input string tag, input logic [2:0] g, input logic [1:0] idx,
                            input logic [7:0] b, input bit ultimo);
    chk({tag, "_load_st"}, bus.db_estado, 4'h1);
    chk({tag, "_load_grant"}, bus.grant, g);
    chk({tag, "_load_idx"}, bus.byte_idx, idx);
    chk({tag, "_load_part"}, bus.partida_tx, 0);
    @(negedge clock);
    chk({tag, "_send_st"}, bus.db_estado, 4'h2);
    chk({tag, "_send_part"}, bus.partida_tx, 1);
    chk({tag, "_send_tx"}, bus.tx_dados, b);
    repeat (4) begin
      @(negedge clock);
      chk({tag, "_wait_st"}, bus.db_estado, 4'h3);
      chk({tag, "_wait_part"}, bus.partida_tx, 0);
    end
    @(negedge clock);
    chk({tag, "_wait_tx"}, bus.tx_dados, b);
    bus.pronto_serial = 1'b1;
    @(negedge clock);
    bus.pronto_serial = 1'b0;
    if (ultimo) begin
      chk({tag, "_done_st"}, bus.db_estado, 4'h4);
      chk({tag, "_done_ack"}, bus.ack, g);
      chk({tag, "_done_grant"}, bus.grant, g);
    end else begin
      chk({tag, "_next_ack"}, bus.ack, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        msg[i][j] = 8'h00;
    bus.req = '0;
    bus.tam = '0;
    bus.pronto_serial = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_grant", bus.grant, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_idx", bus.byte_idx, 0);
    chk("rst_tx", bus.tx_dados, 0);
    chk("rst_part", bus.partida_tx, 0);
    chk("rst_ocup", bus.ocupado, 0);
    chk("rst_st", bus.db_estado, 0);
    reset = 1'b0;

    // Single requester, three bytes
    msg[0][0] = 8'hA1; msg[0][1] = 8'hB2; msg[0][2] = 8'hC3;
    bus.tam = 6'b00_00_10;
    bus.req = 3'b001;
    n0 = n_partida;
    @(negedge clock);
    envia_byte("single_b0", 3'b001, 2'd0, 8'hA1, 0);
    envia_byte("single_b1", 3'b001, 2'd1, 8'hB2, 0);
    envia_byte("single_b2", 3'b001, 2'd2, 8'hC3, 1);
    bus.req = '0;
    @(negedge clock);
    chk("single_idle_st", bus.db_estado, 0);
    chk("single_idle_ack", bus.ack, 0);
    chk("single_npart", n_partida - n0, 3);

    // Contention from a fresh pointer
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    msg[0][0] = 8'h10; msg[1][0] = 8'h20; msg[2][0] = 8'h30;
    bus.tam = '0;
    bus.req = 3'b111;
    @(negedge clock);
    envia_byte("cont_m0", 3'b001, 2'd0, 8'h10, 1);
    @(negedge clock);
    chk("cont_gap0", bus.ocupado, 0);
    @(negedge clock);
    envia_byte("cont_m1", 3'b010, 2'd0, 8'h20, 1);
    @(negedge clock);
    chk("cont_gap1", bus.ocupado, 0);
    @(negedge clock);
    envia_byte("cont_m2", 3'b100, 2'd0, 8'h30, 1);
    @(negedge clock);
    chk("cont_gap2", bus.ocupado, 0);
    @(negedge clock);
    envia_byte("cont_m3", 3'b001, 2'd0, 8'h10, 1);
    bus.req = '0;
    @(negedge clock);
    chk("cont_end_ocup", bus.ocupado, 0);

    // Spurious pronto_serial in IDLE, LOAD and SEND
    msg[0][0] = 8'h5A;
    n0 = n_partida;
    bus.pronto_serial = 1'b1;
    @(negedge clock);
    chk("spur_idle_st", bus.db_estado, 0);
    bus.req = 3'b001;
    @(negedge clock);
    chk("spur_load_st", bus.db_estado, 4'h1);
    bus.req = '0;
    @(negedge clock);
    chk("spur_send_st", bus.db_estado, 4'h2);
    @(negedge clock);
    bus.pronto_serial = 1'b0;
    chk("spur_wait_st", bus.db_estado, 4'h3);
    @(negedge clock);
    chk("spur_wait2_st", bus.db_estado, 4'h3);
    bus.pronto_serial = 1'b1;
    @(negedge clock);
    bus.pronto_serial = 1'b0;
    chk("spur_done_ack", bus.ack, 3'b001);
    @(negedge clock);
    chk("spur_idle2_st", bus.db_estado, 0);
    chk("spur_npart", n_partida - n0, 1);

    // Mid-message req drop and tam change must not affect the message
    msg[1][0] = 8'h11; msg[1][1] = 8'h22; msg[1][2] = 8'h33; msg[1][3] = 8'h44;
    bus.tam = 6'b00_11_00;
    bus.req = 3'b010;
    @(negedge clock);
    envia_byte("drop_b0", 3'b010, 2'd0, 8'h11, 0);
    bus.req = '0;
    bus.tam = '0;
    envia_byte("drop_b1", 3'b010, 2'd1, 8'h22, 0);
    envia_byte("drop_b2", 3'b010, 2'd2, 8'h33, 0);
    envia_byte("drop_b3", 3'b010, 2'd3, 8'h44, 1);
    @(negedge clock);
    chk("drop_idle_st", bus.db_estado, 0);

    // Reset while waiting on byte 2 of requester 2
    msg[2][0] = 8'hC0; msg[2][1] = 8'hC1; msg[2][2] = 8'hC2;
    bus.tam = 6'b10_00_00;
    bus.req = 3'b100;
    @(negedge clock);
    envia_byte("rstw_b0", 3'b100, 2'd0, 8'hC0, 0);
    @(negedge clock);
    chk("rstw_send_tx", bus.tx_dados, 8'hC1);
    @(negedge clock);
    chk("rstw_wait_st", bus.db_estado, 4'h3);
    reset = 1'b1;
    @(negedge clock);
    chk("rstw_grant", bus.grant, 0);
    chk("rstw_ack", bus.ack, 0);
    chk("rstw_idx", bus.byte_idx, 0);
    chk("rstw_tx", bus.tx_dados, 0);
    chk("rstw_part", bus.partida_tx, 0);
    chk("rstw_ocup", bus.ocupado, 0);
    chk("rstw_st", bus.db_estado, 0);
    reset = 1'b0;
    bus.tam = '0;
    bus.req = 3'b111;
    @(negedge clock);
    envia_byte("rstw_first", 3'b001, 2'd0, 8'h5A, 1);
    bus.req = '0;
    @(negedge clock);
    chk("rstw_idle_st", bus.db_estado, 0);

    // Idle hold
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("hold_ocup", bus.ocupado, 0);
      chk("hold_part", bus.partida_tx, 0);
      chk("hold_st", bus.db_estado, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
